sylap_monitor: RTL and testbench

//  Downstream checker for the simulated laser/pulse/start generator. Measures laser period,

---
 rtl/sylap_pkg.sv | 18 +
 rtl/sylap_event_fifo.sv | 42 ++++
 rtl/sylap_monitor.sv | 186 ++++++++++++++++++
 tb/tb_sylap_monitor.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sylap_pkg.sv
// sylap_pkg: event type codes, FSM state encoding and ev_data field layout shared by the monitor.
package sylap_pkg;
  localparam int EV_TYPE_W     = 4;
  localparam int EV_PAYLOAD_W  = 28;
  localparam int PULSE_FIELD_W = 14;
  localparam logic [EV_TYPE_W-1:0] EV_PULSE      = 4'd2;
  localparam logic [EV_TYPE_W-1:0] EV_FRAME      = 4'd3;
  localparam logic [EV_TYPE_W-1:0] EV_PERIOD_ERR = 4'd4;
  localparam logic [EV_TYPE_W-1:0] EV_LOCK       = 4'd5;
  localparam logic [EV_TYPE_W-1:0] EV_UNLOCK     = 4'd6;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
  localparam logic [1:0] ST_ACQUIRE   = 2'd2;
  localparam logic [1:0] ST_LOCKED    = 2'd3;
  function automatic logic [31:0] ev_word(input logic [EV_TYPE_W-1:0] t, input logic [EV_PAYLOAD_W-1:0] p);
    return {t, p};
  endfunction
endpackage

// File: rtl/sylap_event_fifo.sv
// sylap_event_fifo: first-word fall-through FIFO with level; push while full is accepted when a pop frees a slot.
module sylap_event_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    level = wr_q - rd_q;
    empty = level == '0;
    full = level == LW'(DEPTH);
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = clear ? '0 : wr_q + LW'(do_push);
    rd_d = clear ? '0 : rd_q + LW'(do_pop);
    dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (do_push && !clear) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/sylap_monitor.sv
// sylap_monitor: checks laser period lock, pulse timing and frame length of the generator,
// reporting events through a FIFO together with saturating error stats and LEDs.
module sylap_monitor
  import sylap_pkg::*;
#(
  parameter int CNT_W      = 28,
  parameter int ERR_W      = 16,
  parameter int LOCK_N     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             simLaser,
  input  logic             simPulse,
  input  logic             simStart,
  input  logic [CNT_W-1:0] expPeriod,
  input  logic [7:0]       periodTol,
  input  logic [7:0]       expLasersPerStart,
  output logic [31:0]      ev_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic             locked,
  output logic [CNT_W-1:0] periodMin,
  output logic [CNT_W-1:0] periodMax,
  output logic [ERR_W-1:0] periodErrCnt,
  output logic [ERR_W-1:0] frameErrCnt,
  output logic [ERR_W-1:0] dropCnt,
  output logic [7:0]       LED
);
  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  logic laser_q, pulse_q, start_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, pmin_q, pmin_d, pmax_q, pmax_d, diff;
  logic [1:0] state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [ERR_W-1:0] perr_q, perr_d, ferr_q, ferr_d, drop_q, drop_d;
  logic [2:0] sticky_q, sticky_d;
  logic [7:0] lcount_q, lcount_d;
  logic [PULSE_FIELD_W-1:0] pdelay_q, pdelay_d, pwidth_q, pwidth_d;
  logic stat_v_q, stat_v_d, frm_v_q, frm_v_d, pls_v_q, pls_v_d;
  logic [31:0] stat_q, stat_d, frm_q, frm_d, pls_q, pls_d, stat_ev, push_data;
  logic laser_rise, pulse_rise, start_rise, run, good, last, measure;
  logic stat_new, frm_new, frm_err, pls_new, perr_inc, push, pop, full, empty;
  logic [1:0] drops;
  logic [LVL_W-1:0] level;
  always_comb begin
    laser_rise = simLaser & ~laser_q;
    pulse_rise = simPulse & ~pulse_q;
    start_rise = simStart & ~start_q;
    run = enable & ~clear;
    diff = pcnt_q >= expPeriod ? pcnt_q - expPeriod : expPeriod - pcnt_q;
    good = diff <= CNT_W'(periodTol);
    last = run_q == RUN_W'(LOCK_N - 1);
    measure = run & laser_rise & (state_q == ST_ACQUIRE || state_q == ST_LOCKED);
    pcnt_d = laser_rise ? CNT_W'(1) : pcnt_q + CNT_W'(~&pcnt_q);
    state_d = state_q;
    run_d = run_q;
    stat_new = 1'b0;
    perr_inc = 1'b0;
    stat_ev = ev_word(EV_PERIOD_ERR, EV_PAYLOAD_W'(pcnt_q));
    if (!enable) begin
      state_d = ST_IDLE;
      run_d = '0;
    end else if (clear) begin
      state_d = ST_WAIT_EDGE;
      run_d = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_WAIT_EDGE;
    end else if (laser_rise) begin
      if (state_q == ST_WAIT_EDGE) begin
        state_d = ST_ACQUIRE;
      end else if (state_q == ST_ACQUIRE) begin
        run_d = good ? run_q + 1'b1 : '0;
        if (good && last) begin
          state_d = ST_LOCKED;
          run_d = '0;
          stat_new = 1'b1;
          stat_ev = ev_word(EV_LOCK, EV_PAYLOAD_W'(pcnt_q));
        end
      end else begin
        // the period that breaks lock reports UNLOCK in place of PERIOD_ERR
        run_d = good ? '0 : run_q + 1'b1;
        perr_inc = ~good;
        stat_new = ~good;
        if (!good && last) begin
          state_d = ST_ACQUIRE;
          run_d = '0;
          stat_ev = ev_word(EV_UNLOCK, EV_PAYLOAD_W'(pcnt_q));
        end
      end
    end
  end
  always_comb begin
    pop = ev_ready & ~empty;
    push = ~clear & (stat_v_q | frm_v_q | pls_v_q) & (~full | pop);
    push_data = stat_v_q ? stat_q : frm_v_q ? frm_q : pls_q;
    frm_new = run & start_rise & (state_q == ST_LOCKED);
    frm_err = lcount_q != expLasersPerStart;
    pls_new = run & ~simPulse & pulse_q & (state_q == ST_LOCKED);
    stat_v_d = ~clear & (stat_v_q ? ~push : stat_new);
    frm_v_d = ~clear & (frm_v_q ? ~(push & ~stat_v_q) : frm_new);
    pls_v_d = ~clear & (pls_v_q ? ~(push & ~stat_v_q & ~frm_v_q) : pls_new);
    stat_d = stat_v_q ? stat_q : stat_ev;
    frm_d = frm_v_q ? frm_q : ev_word(EV_FRAME, {frm_err, 19'b0, lcount_q});
    pls_d = pls_v_q ? pls_q : ev_word(EV_PULSE, {pdelay_q, pwidth_q});
    drops = 2'(stat_new & stat_v_q) + 2'(frm_new & frm_v_q) + 2'(pls_new & pls_v_q);
    perr_d = clear ? '0 : perr_q + ERR_W'(perr_inc & ~&perr_q);
    ferr_d = clear ? '0 : ferr_q + ERR_W'(frm_new & frm_err & ~&ferr_q);
    drop_d = clear ? '0 : (drop_q > ~ERR_W'(drops)) ? '1 : drop_q + ERR_W'(drops);
    sticky_d = clear ? '0 : sticky_q | {drops != 2'd0, frm_new & frm_err, perr_inc};
    pmin_d = clear ? '1 : (measure && pcnt_q < pmin_q) ? pcnt_q : pmin_q;
    pmax_d = clear ? '0 : (measure && pcnt_q > pmax_q) ? pcnt_q : pmax_q;
    lcount_d = clear ? '0 : start_rise ? {7'b0, laser_rise} : lcount_q + 8'(laser_rise & ~&lcount_q);
    pdelay_d = !pulse_rise ? pdelay_q : laser_rise ? '0 :
               (pcnt_q > CNT_W'(2 ** PULSE_FIELD_W - 1)) ? '1 : pcnt_q[PULSE_FIELD_W-1:0];
    pwidth_d = pulse_rise ? PULSE_FIELD_W'(1) : pwidth_q + PULSE_FIELD_W'(simPulse & ~&pwidth_q);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      laser_q <= 1'b0;
      pulse_q <= 1'b0;
      start_q <= 1'b0;
      pcnt_q <= '0;
      state_q <= ST_IDLE;
      run_q <= '0;
      pmin_q <= '1;
      pmax_q <= '0;
      perr_q <= '0;
      ferr_q <= '0;
      drop_q <= '0;
      sticky_q <= '0;
      lcount_q <= '0;
      pdelay_q <= '0;
      pwidth_q <= '0;
      stat_v_q <= 1'b0;
      frm_v_q <= 1'b0;
      pls_v_q <= 1'b0;
      stat_q <= '0;
      frm_q <= '0;
      pls_q <= '0;
    end else begin
      laser_q <= simLaser;
      pulse_q <= simPulse;
      start_q <= simStart;
      pcnt_q <= pcnt_d;
      state_q <= state_d;
      run_q <= run_d;
      pmin_q <= pmin_d;
      pmax_q <= pmax_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      drop_q <= drop_d;
      sticky_q <= sticky_d;
      lcount_q <= lcount_d;
      pdelay_q <= pdelay_d;
      pwidth_q <= pwidth_d;
      stat_v_q <= stat_v_d;
      frm_v_q <= frm_v_d;
      pls_v_q <= pls_v_d;
      stat_q <= stat_d;
      frm_q <= frm_d;
      pls_q <= pls_d;
    end
  sylap_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .push(push),
    .din(push_data),
    .pop(pop),
    .dout(ev_data),
    .empty(empty),
    .full(full),
    .level(level)
  );
  assign ev_valid = ~empty;
  assign locked = state_q == ST_LOCKED;
  assign periodMin = pmin_q;
  assign periodMax = pmax_q;
  assign periodErrCnt = perr_q;
  assign frameErrCnt = ferr_q;
  assign dropCnt = drop_q;
  assign LED = {(level > 15) ? 4'hF : 4'(level), sticky_q, locked};
endmodule

// File: tb/tb_sylap_monitor.sv
// tb_sylap_monitor: scoreboard bench driving laser/pulse/start patterns and checking events and stats.
module tb_sylap_monitor;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, clear = 1'b0;
  logic simLaser = 1'b0, simPulse = 1'b0, simStart = 1'b0, ev_ready = 1'b1;
  logic [27:0] expPeriod = 28'd20;
  logic [7:0] periodTol = 8'd1, expLasersPerStart = 8'd8;
  logic [31:0] ev_data;
  logic ev_valid, locked;
  logic [27:0] periodMin, periodMax;
  logic [15:0] periodErrCnt, frameErrCnt, dropCnt;
  logic [7:0] LED;
  logic [31:0] sb[$];
  int n_cmp = 0, n_bad = 0, lcnt = 0;

  sylap_monitor dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .simLaser(simLaser), .simPulse(simPulse), .simStart(simStart),
    .expPeriod(expPeriod), .periodTol(periodTol), .expLasersPerStart(expLasersPerStart),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready), .locked(locked),
    .periodMin(periodMin), .periodMax(periodMax), .periodErrCnt(periodErrCnt),
    .frameErrCnt(frameErrCnt), .dropCnt(dropCnt), .LED(LED)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one laser period of p cycles; optional pulse at offset pdel for pw cycles, optional start mid-period
  task automatic period(input int p, input int pdel, input int pw, input bit st, input bit ex);
    lcnt = lcnt < 255 ? lcnt + 1 : 255;
    if (ex && pw > 0) sb.push_back({4'h2, 14'(pdel), 14'(pw)});
    for (int c = 0; c < p; c++) begin
      simLaser = c < 2;
      simPulse = pw > 0 && c >= pdel && c < pdel + pw;
      simStart = st && (c == 10 || c == 11);
      if (st && c == 10) begin
        if (ex) sb.push_back({4'h3, lcnt != 8, 19'b0, 8'(lcnt)});
        lcnt = 0;
      end
      tick();
    end
    simLaser = 1'b0;
    simPulse = 1'b0;
    simStart = 1'b0;
  endtask

  always @(negedge clk)
    if (reset_n && ev_valid && ev_ready) begin
      if (sb.size() == 0) check("ev_unexpected", ev_data, 32'hFFFF_FFFF);
      else check("ev", ev_data, sb.pop_front());
    end

  initial begin
    repeat (3) tick();
    check("rst_locked", 32'(locked), 0);
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_data", ev_data, 0);
    check("rst_pmin", 32'(periodMin), 32'h0FFF_FFFF);
    check("rst_pmax", 32'(periodMax), 0);
    check("rst_drop", 32'(dropCnt), 0);
    check("rst_led", 32'(LED), 0);
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    // lock after the fifth rise
    sb.push_back(32'h5000_0014);
    repeat (5) period(20, 0, 0, 0, 1);
    check("t1_locked", 32'(locked), 1);
    check("t1_pmin", 32'(periodMin), 20);
    check("t1_pmax", 32'(periodMax), 20);
    check("t1_led0", 32'(LED[0]), 1);
    // pulse timing, including a pulse coincident with the laser edge
    period(20, 7, 3, 0, 1);
    period(20, 0, 4, 0, 1);
    // single bad period, then four in a row
    sb.push_back(32'h4000_0019);
    period(25, 0, 0, 0, 1);
    period(20, 0, 0, 0, 1);
    check("t3_perr1", 32'(periodErrCnt), 1);
    check("t3_locked", 32'(locked), 1);
    check("t3_led1", 32'(LED[1]), 1);
    repeat (3) sb.push_back(32'h4000_0019);
    sb.push_back(32'h6000_0019);
    repeat (4) period(25, 0, 0, 0, 1);
    period(20, 0, 0, 0, 1);
    check("t3_unlocked", 32'(locked), 0);
    check("t3_perr5", 32'(periodErrCnt), 5);
    check("t3_pmax", 32'(periodMax), 25);
    check("t3_pmin", 32'(periodMin), 20);
    sb.push_back(32'h5000_0014);
    repeat (4) period(20, 0, 0, 0, 1);
    check("t3_relocked", 32'(locked), 1);
    // overflow: 16 in FIFO, 1 pending, 3 dropped
    ev_ready = 1'b0;
    for (int i = 0; i < 20; i++) period(20, 3 + i % 10, 1 + i % 5, 0, i < 17);
    check("t5_valid", 32'(ev_valid), 1);
    check("t5_drop", 32'(dropCnt), 3);
    check("t5_led", 32'(LED), 32'hFB);
    ev_ready = 1'b1;
    repeat (2) period(20, 0, 0, 0, 1);
    check("t5_drained", 32'(sb.size()), 0);
    check("t5_empty", 32'(ev_valid), 0);
    // asynchronous reset with five words queued
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) period(20, 5, 2, 0, 0);
    check("t6_led_pre", 32'(LED), 32'h5B);
    simLaser = 1'b1;
    repeat (2) tick();
    simLaser = 1'b0;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check("t6_valid", 32'(ev_valid), 0);
    check("t6_locked", 32'(locked), 0);
    check("t6_pmin", 32'(periodMin), 32'h0FFF_FFFF);
    check("t6_drop", 32'(dropCnt), 0);
    check("t6_led", 32'(LED), 0);
    sb.delete();
    lcnt = 0;
    ev_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    sb.push_back(32'h5000_0014);
    repeat (5) period(20, 0, 0, 0, 1);
    check("t6_relocked", 32'(locked), 1);
    // framing: 8, 8 then 7 lasers per start
    repeat (2) period(20, 0, 0, 0, 1);
    period(20, 0, 0, 1, 1);
    repeat (7) period(20, 0, 0, 0, 1);
    period(20, 0, 0, 1, 1);
    check("t4_ferr0", 32'(frameErrCnt), 0);
    repeat (6) period(20, 0, 0, 0, 1);
    period(20, 0, 0, 1, 1);
    check("t4_ferr1", 32'(frameErrCnt), 1);
    check("t4_led", 32'(LED), 32'h05);
    repeat (10) tick();
    check("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
